// File: rtl/motor_shutdown_seq_pkg.sv
// Shared definitions for the motor shutdown sequencer: state encodings,
// default timing constants and the timer sizing helper.
package motor_shutdown_seq_pkg;

  typedef enum logic [1:0] {
    S_SAFE  = 2'b00,
    S_REARM = 2'b01,
    S_RUN   = 2'b10,
    S_BRAKE = 2'b11
  } seq_state_t;

  localparam int C_CLK_HZ       = 1000;
  localparam int C_BRAKE_MS_DEF = 250;
  localparam int C_REARM_MS_DEF = 125;

  // One timer serves both BRAKE and REARM, so it is sized for the longer one.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/motor_shutdown_seq_if.sv
// Status/control bundle between the shutdown sequencer (slave) and its
// environment (master: watchdog trip source and operator panel).
interface motor_shutdown_seq_if #(
  parameter int C_CNT_W = 8
);
  logic               wd_trip;
  logic               rearm_req;
  logic               motor_en;
  logic               brake_on;
  logic               fault_latched;
  logic [1:0]         seq_state;
  logic [C_CNT_W-1:0] trip_count;

  modport master (
    output wd_trip,
    output rearm_req,
    input  motor_en,
    input  brake_on,
    input  fault_latched,
    input  seq_state,
    input  trip_count
  );

  modport slave (
    input  wd_trip,
    input  rearm_req,
    output motor_en,
    output brake_on,
    output fault_latched,
    output seq_state,
    output trip_count
  );
endinterface

// File: rtl/motor_shutdown_seq_rise_edge_det.sv
// Rising-edge detector (one history flop + AND). No edge is reported on the
// first sample after reset, so a level already high across reset release does not fire.
module rise_edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_rise
);
  logic r_prev;
  logic r_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_prev  <= i_sig;
      r_valid <= 1'b1;
    end
  end

  assign o_rise = i_sig & ~r_prev & r_valid;
endmodule

// File: rtl/motor_shutdown_seq.sv
// Staged motor shutdown: latches a watchdog trip into BRAKE, parks in SAFE,
// and returns to RUN only after a supervised REARM window. Counts trips.
module motor_shutdown_seq
  import motor_shutdown_seq_pkg::*;
#(
  parameter int C_BRAKE_MS = C_BRAKE_MS_DEF,
  parameter int C_REARM_MS = C_REARM_MS_DEF,
  parameter int C_CNT_W    = 8
) (
  input  logic                 i_clk_1khz,
  input  logic                 i_rst_n,
  motor_shutdown_seq_if.slave  bus
);

  localparam int                 TMR_W      = timer_width(C_BRAKE_MS, C_REARM_MS);
  localparam logic [TMR_W-1:0]   BRAKE_LAST = TMR_W'(C_BRAKE_MS - 1);
  localparam logic [TMR_W-1:0]   REARM_LAST = TMR_W'(C_REARM_MS - 1);
  localparam logic [C_CNT_W-1:0] CNT_MAX    = '1;

  seq_state_t         r_state;
  seq_state_t         w_next_state;
  logic [TMR_W-1:0]   r_timer;
  logic [C_CNT_W-1:0] r_trip_count;
  logic               r_fault;
  logic               r_motor_en;
  logic               r_brake_on;
  logic               w_rearm_rise;
  logic               w_enter_brake;
  logic               w_rearm_pass;
  logic               w_motor_en_d;
  logic               w_brake_on_d;

  rise_edge_det u_rearm_edge (
    .i_clk   (i_clk_1khz),
    .i_rst_n (i_rst_n),
    .i_sig   (bus.rearm_req),
    .o_rise  (w_rearm_rise)
  );

  always_ff @(posedge i_clk_1khz or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_SAFE;
    else          r_state <= w_next_state;
  end

  // A trip in REARM beats a simultaneous timer expiry; BRAKE ignores all inputs.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_SAFE:  if (w_rearm_rise) w_next_state = S_REARM;
      S_REARM: begin
        if (bus.wd_trip)               w_next_state = S_BRAKE;
        else if (r_timer == REARM_LAST) w_next_state = S_RUN;
      end
      S_RUN:   if (bus.wd_trip) w_next_state = S_BRAKE;
      S_BRAKE: if (r_timer == BRAKE_LAST) w_next_state = S_SAFE;
      default: w_next_state = S_SAFE;
    endcase
  end

  assign w_enter_brake = (w_next_state == S_BRAKE) && (r_state != S_BRAKE);
  assign w_rearm_pass  = (r_state == S_REARM) && (w_next_state == S_RUN);

  always_comb begin
    w_motor_en_d = (w_next_state == S_REARM) || (w_next_state == S_RUN);
    w_brake_on_d = (w_next_state == S_BRAKE);
  end

  always_ff @(posedge i_clk_1khz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_motor_en <= 1'b0;
      r_brake_on <= 1'b0;
    end else begin
      r_motor_en <= w_motor_en_d;
      r_brake_on <= w_brake_on_d;
    end
  end

  // Timer restarts on every state change, so each state measures its own dwell.
  always_ff @(posedge i_clk_1khz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_timer <= '0;
    end else if (w_next_state != r_state) begin
      r_timer <= '0;
    end else if ((r_state == S_REARM && !bus.wd_trip) || r_state == S_BRAKE) begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  always_ff @(posedge i_clk_1khz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_trip_count <= '0;
      r_fault      <= 1'b0;
    end else begin
      if (w_enter_brake && r_trip_count != CNT_MAX)
        r_trip_count <= r_trip_count + C_CNT_W'(1);
      if (w_enter_brake)
        r_fault <= 1'b1;
      else if (w_rearm_pass)
        r_fault <= 1'b0;
    end
  end

  assign bus.motor_en      = r_motor_en;
  assign bus.brake_on      = r_brake_on;
  assign bus.fault_latched = r_fault;
  assign bus.seq_state     = r_state;
  assign bus.trip_count    = r_trip_count;

  a_no_drive_and_brake: assert property (
    @(posedge i_clk_1khz) disable iff (!i_rst_n) !(r_motor_en && r_brake_on)
  );

endmodule

// File: tb/tb_motor_shutdown_seq.sv
// Randomised bench for motor_shutdown_seq: a driver feeds a cycle-based reference
// model and queues expected outputs; a monitor pops and compares every clock.
module tb_motor_shutdown_seq;

  localparam int BRAKE_MS = 250;
  localparam int REARM_MS = 125;
  localparam int CNT_W    = 2;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam int PH_SAFE  = 0;
  localparam int PH_REARM = 1;
  localparam int PH_RUN   = 2;
  localparam int PH_BRAKE = 3;

  typedef struct packed {
    logic [1:0]       st;
    logic             men;
    logic             bon;
    logic             flt;
    logic [CNT_W-1:0] cnt;
  } expT;

  logic clk_1khz = 1'b0;
  logic rst_n    = 1'b0;

  always #5 clk_1khz = ~clk_1khz;

  motor_shutdown_seq_if #(.C_CNT_W(CNT_W)) bus();

  motor_shutdown_seq #(
    .C_BRAKE_MS (BRAKE_MS),
    .C_REARM_MS (REARM_MS),
    .C_CNT_W    (CNT_W)
  ) dut (
    .i_clk_1khz (clk_1khz),
    .i_rst_n    (rst_n),
    .bus        (bus)
  );

  expT expQ[$];
  int  checks   = 0;
  int  failures = 0;
  int  cycleNo  = 0;

  int  mPhase;
  int  mBrakeLeft;
  int  mRearmOk;
  int  mTrips;
  bit  mFault;
  bit  mPrevReq;
  bit  mSeen;

  task automatic modelReset();
    mPhase     = PH_SAFE;
    mBrakeLeft = 0;
    mRearmOk   = 0;
    mTrips     = 0;
    mFault     = 1'b0;
    mPrevReq   = 1'b0;
    mSeen      = 1'b0;
  endtask

  task automatic modelTrip();
    mPhase     = PH_BRAKE;
    mBrakeLeft = BRAKE_MS;
    mFault     = 1'b1;
    if (mTrips < CNT_MAX) mTrips++;
  endtask

  // One clock edge of behaviour, given the inputs sampled on that edge.
  task automatic modelStep(input bit wd, input bit rq);
    bit rise;
    rise     = rq && !mPrevReq && mSeen;
    mPrevReq = rq;
    mSeen    = 1'b1;
    case (mPhase)
      PH_SAFE: if (rise) begin
        mPhase   = PH_REARM;
        mRearmOk = 0;
      end
      PH_REARM: begin
        if (wd) modelTrip();
        else begin
          mRearmOk++;
          if (mRearmOk == REARM_MS) begin
            mPhase = PH_RUN;
            mFault = 1'b0;
          end
        end
      end
      PH_RUN: if (wd) modelTrip();
      default: begin
        mBrakeLeft--;
        if (mBrakeLeft == 0) mPhase = PH_SAFE;
      end
    endcase
  endtask

  function automatic expT modelOutputs();
    expT e;
    e.st  = 2'(mPhase);
    e.men = (mPhase == PH_REARM) || (mPhase == PH_RUN);
    e.bon = (mPhase == PH_BRAKE);
    e.flt = mFault;
    e.cnt = CNT_W'(mTrips);
    return e;
  endfunction

  task automatic checkOutput(input string name, input expT exp);
    expT act;
    act.st  = bus.seq_state;
    act.men = bus.motor_en;
    act.bon = bus.brake_on;
    act.flt = bus.fault_latched;
    act.cnt = bus.trip_count;
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got state=%0d motor_en=%0b brake_on=%0b fault=%0b trips=%0d, required state=%0d motor_en=%0b brake_on=%0b fault=%0b trips=%0d",
               name, act.st, act.men, act.bon, act.flt, act.cnt,
               exp.st, exp.men, exp.bon, exp.flt, exp.cnt);
    end
  endtask

  // Called on a falling edge; leaves the driver on a falling edge.
  task automatic applyStimulus(input bit wd, input bit rq, input int n);
    repeat (n) begin
      bus.wd_trip   = wd;
      bus.rearm_req = rq;
      modelStep(wd, rq);
      expQ.push_back(modelOutputs());
      @(negedge clk_1khz);
    end
  endtask

  task automatic pulseRearm();
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 1);
  endtask

  // Brake dwell while hammering the inputs the sequencer must ignore.
  task automatic noisyBrake(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'($urandom_range(0, 1)), (i % 20) < 3, 1);
  endtask

  task automatic doReset(input bit rq, input int n);
    rst_n         = 1'b0;
    bus.wd_trip   = 1'b0;
    bus.rearm_req = rq;
    modelReset();
    #1;
    checkOutput("async reset", modelOutputs());
    repeat (n) begin
      expQ.push_back(modelOutputs());
      @(negedge clk_1khz);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    expT e;
    forever begin
      @(posedge clk_1khz);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        cycleNo++;
        checkOutput($sformatf("cycle %0d", cycleNo), e);
      end
    end
  end

  initial begin
    int pcts[4];
    bit rq;
    bit wd;
    int pct;
    pcts[0] = 0;
    pcts[1] = 2;
    pcts[2] = 10;
    pcts[3] = 60;
    bus.wd_trip   = 1'b0;
    bus.rearm_req = 1'b0;
    modelReset();
    @(negedge clk_1khz);

    doReset(1'b0, 3);
    applyStimulus(1'b0, 1'b0, 20);

    pulseRearm();
    applyStimulus(1'b0, 1'b0, 140);

    applyStimulus(1'b1, 1'b0, 1);
    noisyBrake(249);
    applyStimulus(1'b0, 1'b0, 20);

    pulseRearm();
    applyStimulus(1'b0, 1'b0, 57);
    applyStimulus(1'b1, 1'b0, 1);
    noisyBrake(249);
    applyStimulus(1'b0, 1'b0, 20);

    pulseRearm();
    applyStimulus(1'b0, 1'b0, 130);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 99);
    doReset(1'b1, 3);
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 2);
    applyStimulus(1'b0, 1'b1, 2);
    applyStimulus(1'b0, 1'b0, 122);
    applyStimulus(1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 260);

    repeat (5) begin
      pulseRearm();
      applyStimulus(1'b0, 1'b0, 10);
      applyStimulus(1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 260);
    end

    rq = 1'b0;
    for (int blk = 0; blk < 15; blk++) begin
      pct = pcts[$urandom_range(0, 3)];
      repeat (200) begin
        wd = ($urandom_range(0, 99) < pct);
        if ($urandom_range(0, 9) == 0) rq = ~rq;
        applyStimulus(wd, rq, 1);
      end
    end
    applyStimulus(1'b0, 1'b0, 2);

    @(posedge clk_1khz);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL queue drained: got %0d pending, required 0", expQ.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
